seven_seg_scan_controller: RTL

- Parametrised time-multiplexed seven-segment display driver for N digits that share one segment bus.
- Holds a per-digit register file written by a simple write port: 4-bit value, enable and blink per digit.
- Scans the digits round-robin and adds a ghosting guard interval, blink timing, optional hex decode and leading-zero suppression.
- Sits between datapath logic and board pins. It is the scanned successor of the static per-digit BCD decoder/control blocks.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seven_seg_glyph_decode.sv | 34 +++
 rtl/seven_seg_scan_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and active-low glyph constants for the seven-segment display blocks.
// Segment vectors are ordered g..a, so bit0 drives segment a.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   typedef struct packed {
      logic [3:0] value;
      logic       on;
      logic       blink;
   } digit_entry_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t GLYPH_0 = 7'b1000000;
   localparam seg_t GLYPH_1 = 7'b1111001;
   localparam seg_t GLYPH_2 = 7'b0100100;
   localparam seg_t GLYPH_3 = 7'b0110000;
   localparam seg_t GLYPH_4 = 7'b0011001;
   localparam seg_t GLYPH_5 = 7'b0010010;
   localparam seg_t GLYPH_6 = 7'b0000010;
   localparam seg_t GLYPH_7 = 7'b1111000;
   localparam seg_t GLYPH_8 = 7'b0000000;
   localparam seg_t GLYPH_9 = 7'b0010000;
   localparam seg_t GLYPH_A = 7'b0001000;
   localparam seg_t GLYPH_B = 7'b0000011;
   localparam seg_t GLYPH_C = 7'b1000110;
   localparam seg_t GLYPH_D = 7'b0100001;
   localparam seg_t GLYPH_E = 7'b0000110;
   localparam seg_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational 4-bit value to active-low segment decoder.
// With hex_mode_i low, values 10-15 decode to blank.
module seven_seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic       hex_mode_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (value_i)
         4'd0:  seg_o = GLYPH_0;
         4'd1:  seg_o = GLYPH_1;
         4'd2:  seg_o = GLYPH_2;
         4'd3:  seg_o = GLYPH_3;
         4'd4:  seg_o = GLYPH_4;
         4'd5:  seg_o = GLYPH_5;
         4'd6:  seg_o = GLYPH_6;
         4'd7:  seg_o = GLYPH_7;
         4'd8:  seg_o = GLYPH_8;
         4'd9:  seg_o = GLYPH_9;
         4'd10: seg_o = hex_mode_i ? GLYPH_A : SEG_BLANK;
         4'd11: seg_o = hex_mode_i ? GLYPH_B : SEG_BLANK;
         4'd12: seg_o = hex_mode_i ? GLYPH_C : SEG_BLANK;
         4'd13: seg_o = hex_mode_i ? GLYPH_D : SEG_BLANK;
         4'd14: seg_o = hex_mode_i ? GLYPH_E : SEG_BLANK;
         4'd15: seg_o = hex_mode_i ? GLYPH_F : SEG_BLANK;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed N-digit seven-segment driver: digit register file, round-robin scan
// with a deselected guard interval, blink timing and leading-zero suppression.
module seven_seg_scan_controller
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 1000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 32,
   parameter int HEX_MODE     = 1,
   localparam int AW          = $clog2(NUM_DIGITS)
)(
   input  logic                  clock,
   input  logic                  reset_L,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [3:0]            wr_value,
   input  logic                  wr_on,
   input  logic                  wr_blink,
   input  logic                  lz_en,
   output logic [6:0]            seg_L,
   output logic [NUM_DIGITS-1:0] dig_L,
   output logic                  frame_done
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   digit_entry_t            entries_q [NUM_DIGITS];
   logic [SW-1:0]           slot_q, slot_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic [FW-1:0]           frame_q, frame_d;
   logic                    blink_q, blink_d;
   seg_t                    seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    fd_q, fd_d;

   logic                    slot_last, idx_last, frame_last, in_guard;
   digit_entry_t            cur;
   seg_t                    glyph;
   logic [NUM_DIGITS-1:0]   zero_above;
   logic                    nz;

   assign slot_last  = (slot_q == SW'(SCAN_DIV - 1));
   assign idx_last   = (idx_q == AW'(NUM_DIGITS - 1));
   assign frame_last = (frame_q == FW'(BLINK_FRAMES - 1));
   assign in_guard   = (slot_q < SW'(GUARD));
   assign cur        = entries_q[idx_q];

   // Addresses beyond NUM_DIGITS-1 match no entry and are dropped.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < NUM_DIGITS; i++) entries_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && (wr_addr == AW'(i)))
               entries_q[i] <= '{value: wr_value, on: wr_on, blink: wr_blink};
         end
      end
   end

   always_comb begin
      slot_d  = slot_last ? '0 : slot_q + 1'b1;
      idx_d   = idx_q;
      frame_d = frame_q;
      blink_d = blink_q;
      if (slot_last) begin
         idx_d = idx_last ? '0 : idx_q + 1'b1;
         if (idx_last) begin
            if (frame_last) begin
               frame_d = '0;
               blink_d = ~blink_q;
            end else begin
               frame_d = frame_q + 1'b1;
            end
         end
      end
   end

   // zero_above[j]: no enabled non-zero digit at position j or higher.
   always_comb begin
      nz         = 1'b0;
      zero_above = '0;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         nz            = nz | (entries_q[j].on && (entries_q[j].value != 4'd0));
         zero_above[j] = ~nz;
      end
   end

   seven_seg_glyph_decode u_glyph (
      .value_i    (cur.value),
      .hex_mode_i (HEX_MODE != 0),
      .seg_o      (glyph)
   );

   always_comb begin
      seg_d = SEG_BLANK;
      dig_d = '1;
      fd_d  = slot_last && idx_last;
      if (!in_guard) begin
         dig_d = ~(NUM_DIGITS'(1) << idx_q);
         if (cur.on && !(cur.blink && blink_q) &&
             !(lz_en && (idx_q != '0) && zero_above[idx_q]))
            seg_d = glyph;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         slot_q  <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         blink_q <= 1'b0;
         seg_q   <= SEG_BLANK;
         dig_q   <= '1;
         fd_q    <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         fd_q    <= fd_d;
      end
   end

   assign seg_L      = seg_q;
   assign dig_L      = dig_q;
   assign frame_done = fd_q;

endmodule
